// File: rtl/exec_ctrl.sv
// rtl/exec_ctrl.sv - execution controller: single-step, rate-limited run, breakpoint/halt, retired count
module exec_ctrl #(
  parameter int         PC_W     = 8,
  parameter int         DIV_W    = 24,
  parameter int         CNT_W    = 16,
  parameter logic [3:0] HALT_OPC = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_pb,
  input  logic             run_sw,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [DIV_W-1:0] rate_div,
  input  logic [PC_W-1:0]  pc,
  input  logic [3:0]       opcode,
  output logic             core_en,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_BRK  = 2'b10
  } state_t;

  state_t           cur_state;
  state_t           nxt_state;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [DIV_W-1:0] eff_m1;
  logic             skip_bp;
  logic             skip_nxt;
  logic             step_q;
  logic             step_ok;
  logic             at_decision;
  logic             stop_hit;
  logic             issue;

  // A step counts only as a fresh press, and never while a pulse is still out.
  assign step_ok = step_pb & ~step_q & ~core_en;

  // Issue interval clamps to 2 so the PC has settled before the next sample.
  assign eff_m1 = (rate_div <= DIV_W'(2)) ? DIV_W'(1) : (rate_div - DIV_W'(1));

  // >= rather than == so a shrinking rate_div fires immediately instead of wrapping.
  assign at_decision = (div_cnt >= eff_m1);

  assign stop_hit = (bp_en && (pc == bp_addr)) || (opcode == HALT_OPC);

  assign state  = cur_state;
  assign bp_hit = (cur_state == S_BRK);

  // Next-state, divider, skip flag and issue decision.
  always_comb begin
    nxt_state = cur_state;
    div_nxt   = div_cnt;
    skip_nxt  = skip_bp;
    issue     = 1'b0;
    case (cur_state)
      S_IDLE: begin
        div_nxt = '0;
        if (step_ok) begin
          issue = 1'b1;
        end else if (run_sw && !halt_req) begin
          nxt_state = S_RUN;
        end
      end
      S_RUN: begin
        if (halt_req || !run_sw) begin
          nxt_state = S_IDLE;
          div_nxt   = '0;
        end else if (at_decision) begin
          div_nxt = '0;
          if (!skip_bp && stop_hit) begin
            nxt_state = S_BRK;
          end else begin
            issue = 1'b1;
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      S_BRK: begin
        div_nxt = '0;
        if (step_ok) begin
          issue     = 1'b1;
          nxt_state = S_IDLE;
        end else if (!run_sw || halt_req) begin
          nxt_state = S_IDLE;
          skip_nxt  = 1'b1;
        end
      end
      default: begin
        nxt_state = S_IDLE;
        div_nxt   = '0;
      end
    endcase
    // Any issue consumes the one-shot breakpoint bypass.
    if (issue) begin
      skip_nxt = 1'b0;
    end
  end

  // Control state registers; a button held through reset must not step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state <= S_IDLE;
      div_cnt   <= '0;
      skip_bp   <= 1'b0;
      step_q    <= 1'b1;
      core_en   <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      div_cnt   <= div_nxt;
      skip_bp   <= skip_nxt;
      step_q    <= step_pb;
      core_en   <= issue;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if (core_en) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// tb/tb_exec_ctrl.sv - self-checking bench for exec_ctrl
module tb_exec_ctrl;

  localparam int PC_W  = 8;
  localparam int DIV_W = 24;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             step_pb;
  logic             run_sw;
  logic             halt_req;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [DIV_W-1:0] rate_div;
  logic [PC_W-1:0]  pc;
  logic [3:0]       opcode;
  logic             core_en;
  logic [1:0]       state;
  logic             bp_hit;
  logic [CNT_W-1:0] retired;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ret = 0;

  exec_ctrl #(.PC_W(PC_W), .DIV_W(DIV_W), .CNT_W(CNT_W), .HALT_OPC(4'hF)) dut (
    .clk(clk), .reset(reset), .step_pb(step_pb), .run_sw(run_sw), .halt_req(halt_req),
    .bp_en(bp_en), .bp_addr(bp_addr), .rate_div(rate_div), .pc(pc), .opcode(opcode),
    .core_en(core_en), .state(state), .bp_hit(bp_hit), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock; the bench plays the program counter, advancing on each pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    if (core_en === 1'b1) pc = pc + 8'd1;
  endtask

  task automatic do_step();
    step_pb = 1'b0; tick();
    step_pb = 1'b1; tick();
    step_pb = 1'b0; tick();
  endtask

  // Run for several periods and check the pulse train against k % eff == 0.
  task automatic run_rate(input int rd);
    int eff;
    int n;
    eff      = (rd < 2) ? 2 : rd;
    n        = 3 * eff + 1;
    rate_div = DIV_W'(rd);
    run_sw   = 1'b1;
    tick();
    check("run_enter", 32'(state), 32'd1);
    for (int k = 1; k <= n; k++) begin
      tick();
      check($sformatf("run_rate%0d_k%0d", rd, k), 32'(core_en), 32'((k % eff) == 0));
      if ((k % eff) == 0) exp_ret = (exp_ret + 1) % 16;
    end
    run_sw = 1'b0;
    tick();
    check("run_exit", 32'(state), 32'd0);
    check("run_retired", 32'(retired), 32'(exp_ret));
  endtask

  initial begin
    int pulses;
    int prev_lvl;
    int edge_v;
    int rd;

    reset = 1'b0; step_pb = 1'b1; run_sw = 1'b0; halt_req = 1'b0; bp_en = 1'b0;
    bp_addr = '0; rate_div = '0; pc = '0; opcode = 4'h0;
    tick(); tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_core_en", 32'(core_en), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_bp_hit", 32'(bp_hit), 32'd0);

    // Button held through reset release must not step.
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (core_en === 1'b1) pulses++; end
    check("held_no_step", 32'(pulses), 32'd0);

    // Single step: one pulse one cycle after the edge.
    step_pb = 1'b0; tick();
    step_pb = 1'b1; tick();
    check("step_pulse", 32'(core_en), 32'd1);
    step_pb = 1'b0; tick();
    exp_ret = 1;
    check("step_pulse_end", 32'(core_en), 32'd0);
    check("step_retired", 32'(retired), 32'd1);
    check("step_state", 32'(state), 32'd0);

    // Random button activity in IDLE: a pulse follows every rising edge.
    prev_lvl = 0;
    for (int i = 0; i < 40; i++) begin
      step_pb = 1'($urandom_range(0, 1));
      edge_v  = (step_pb && prev_lvl == 0) ? 1 : 0;
      prev_lvl = int'(step_pb);
      tick();
      check("rand_step", 32'(core_en), 32'(edge_v));
      exp_ret = (exp_ret + edge_v) % 16;
    end
    step_pb = 1'b0; tick();
    check("rand_step_retired", 32'(retired), 32'(exp_ret));
    check("rand_step_state", 32'(state), 32'd0);

    // Step edge together with run_sw rising: step wins, RUN one cycle later.
    step_pb = 1'b1; run_sw = 1'b1; tick();
    exp_ret = (exp_ret + 1) % 16;
    check("simul_pulse", 32'(core_en), 32'd1);
    check("simul_idle", 32'(state), 32'd0);
    step_pb = 1'b0; tick();
    check("simul_run", 32'(state), 32'd1);
    run_sw = 1'b0; tick();
    check("simul_exit", 32'(state), 32'd0);

    // Run rates.
    run_rate(5);
    run_rate(0);
    for (int j = 0; j < 3; j++) run_rate(int'($urandom_range(1, 7)));

    // Breakpoint at PC 6 starting from PC 0.
    rd = int'($urandom_range(0, 4));
    rate_div = DIV_W'(rd);
    bp_en = 1'b1; bp_addr = 8'h06; pc = 8'h00;
    run_sw = 1'b1;
    pulses = 0;
    for (int i = 0; i < 200 && state !== 2'b10; i++) begin
      tick();
      if (core_en === 1'b1) pulses++;
    end
    exp_ret = (exp_ret + 6) % 16;
    check("bp_pulses", 32'(pulses), 32'd6);
    check("bp_state", 32'(state), 32'd2);
    check("bp_hit", 32'(bp_hit), 32'd1);
    check("bp_retired", 32'(retired), 32'(exp_ret));
    check("bp_pc", 32'(pc), 32'h06);

    // Resume: the stopping instruction executes once.
    run_sw = 1'b0; tick();
    check("resume_idle", 32'(state), 32'd0);
    run_sw = 1'b1; tick();
    check("resume_run", 32'(state), 32'd1);
    pulses = 0;
    for (int i = 0; i < 20 && pulses == 0; i++) begin
      tick();
      if (core_en === 1'b1) pulses++;
    end
    exp_ret = (exp_ret + 1) % 16;
    check("resume_pulse", 32'(pulses), 32'd1);
    check("resume_pc", 32'(pc), 32'h07);
    check("resume_still_run", 32'(state), 32'd1);

    // Jump back to PC 5: PC 6 is revisited and halts again.
    pc = 8'h05;
    pulses = 0;
    for (int i = 0; i < 200 && state !== 2'b10; i++) begin
      tick();
      if (core_en === 1'b1) pulses++;
    end
    exp_ret = (exp_ret + 1) % 16;
    check("revisit_pulses", 32'(pulses), 32'd1);
    check("revisit_state", 32'(state), 32'd2);
    check("revisit_pc", 32'(pc), 32'h06);
    run_sw = 1'b0; tick();
    bp_en = 1'b0;
    check("revisit_exit", 32'(state), 32'd0);

    // Clear the pending bypass with a plain step before the halt-opcode test.
    do_step();
    exp_ret = (exp_ret + 1) % 16;

    // Halt opcode: BRK with no pulse, then a step leaves BRK with one pulse.
    opcode = 4'hF;
    rate_div = DIV_W'($urandom_range(0, 4));
    run_sw = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50 && state !== 2'b10; i++) begin
      tick();
      if (core_en === 1'b1) pulses++;
    end
    check("hopc_pulses", 32'(pulses), 32'd0);
    check("hopc_state", 32'(state), 32'd2);
    step_pb = 1'b1; tick();
    exp_ret = (exp_ret + 1) % 16;
    check("hopc_step_pulse", 32'(core_en), 32'd1);
    check("hopc_step_state", 32'(state), 32'd0);
    run_sw = 1'b0; step_pb = 1'b0; opcode = 4'h0; tick();
    check("hopc_idle", 32'(state), 32'd0);
    check("hopc_retired", 32'(retired), 32'(exp_ret));

    // halt_req at the decision point: no pulse.
    rate_div = DIV_W'(3);
    run_sw = 1'b1; tick();
    pulses = 0;
    tick(); if (core_en === 1'b1) pulses++;
    tick(); if (core_en === 1'b1) pulses++;
    halt_req = 1'b1; tick(); if (core_en === 1'b1) pulses++;
    check("halt_state", 32'(state), 32'd0);
    tick(); if (core_en === 1'b1) pulses++;
    check("halt_no_pulse", 32'(pulses), 32'd0);
    halt_req = 1'b0; run_sw = 1'b0; tick();

    // A pulse already registered when halt_req rises still completes.
    rate_div = DIV_W'(2);
    run_sw = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20 && pulses == 0; i++) begin
      tick();
      if (core_en === 1'b1) pulses++;
    end
    check("inflight_seen", 32'(pulses), 32'd1);
    exp_ret = (exp_ret + 1) % 16;
    halt_req = 1'b1; tick();
    check("inflight_state", 32'(state), 32'd0);
    check("inflight_retired", 32'(retired), 32'(exp_ret));
    halt_req = 1'b0; run_sw = 1'b0; tick();

    // Counter wrap: 17 steps on a 4-bit counter leaves 1.
    step_pb = 1'b0; reset = 1'b0; tick(); reset = 1'b1;
    check("wrap_cleared", 32'(retired), 32'd0);
    for (int i = 0; i < 17; i++) do_step();
    check("wrap_retired", 32'(retired), 32'd1);

    // Asynchronous reset in the middle of a RUN pulse.
    rate_div = DIV_W'(4);
    run_sw = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20 && pulses == 0; i++) begin
      tick();
      if (core_en === 1'b1) pulses++;
    end
    check("areset_pulse_seen", 32'(pulses), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("areset_core_en", 32'(core_en), 32'd0);
    check("areset_state", 32'(state), 32'd0);
    check("areset_retired", 32'(retired), 32'd0);
    check("areset_bp_hit", 32'(bp_hit), 32'd0);
    run_sw = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("areset_after", 32'(state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Execution controller for the 16-bit single-cycle core. It replaces direct pushbutton clocking of the program counter, register file and data memory with a one-cycle `core_en` enable in the system clock domain. It supports three modes: single-step, free-run at a programmable rate, and halt on a PC breakpoint or a halt opcode. It also counts retired instructions for display and debug probing.

## Interface
Parameters:
- `PC_W`, 8, program counter width
- `DIV_W`, 24, run-rate divider width
- `CNT_W`, 16, retired-instruction counter width
- `HALT_OPC`, 4'hF, opcode that stops run mode

Ports:
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  asynchronous, active-low reset
- `step_pb`  in  1  debounced step button level, synchronous to `clk`
- `run_sw`  in  1  run request level (1 = run)
- `halt_req`  in  1  forced stop, level
- `bp_en`  in  1  breakpoint enable
- `bp_addr`  in  PC_W  breakpoint PC
- `rate_div`  in  DIV_W  run mode issue interval in `clk` cycles
- `pc`  in  PC_W  current PC from the program counter
- `opcode`  in  4  opcode of the current instruction
- `core_en`  out  1  one-cycle enable to the PC, regfile and data memory write
- `state`  out  2  00 IDLE, 01 RUN, 10 BRK
- `bp_hit`  out  1  high while in BRK
- `retired`  out  CNT_W  count of `core_en` pulses

## Operation
- **Registers:**
  - FSM state.
  - `step_q` edge-detect register.
  - `div_cnt` (DIV_W).
  - `skip_bp` flag.
  - `core_en`, which is registered.
  - `retired`.
- **Issue decision:** a decision made in cycle t drives `core_en`=1 in cycle t+1 only. `pc` and `opcode` are sampled at the decision cycle.
- **Step detection:**
  - A step edge is `step_pb & ~step_q`.
  - It is accepted only in IDLE or BRK, and only when `core_en`=0. Otherwise it is dropped.
  - A step always issues, with no breakpoint or halt-opcode check.
- **IDLE:**
  - Step edge: issue; stay IDLE.
  - `run_sw`=1 and `halt_req`=0: go to RUN and set `div_cnt`=0.
- **RUN:**
  - `div_cnt` increments each cycle. The decision point is `div_cnt` == eff−1, where eff = max(`rate_div`, 2); `div_cnt` then reloads 0.
  - The priority order is:
    1. `halt_req` → IDLE.
    2. `run_sw`=0 → IDLE.
    3. At the decision point, if `skip_bp`=0 and ((`bp_en` and `pc`==`bp_addr`) or `opcode`==`HALT_OPC`) → BRK with no issue.
    4. Otherwise, at the decision point, issue.
  - The first two apply in any RUN cycle, not only at decision points.
- **BRK:**
  - Step edge: issue, then go to IDLE.
  - `run_sw`=0 or `halt_req`: go to IDLE.
  - `run_sw` held at 1: stay in BRK.
- **`skip_bp`:**
  - Set on any BRK→IDLE transition.
  - Cleared in the cycle any issue is decided, and on reset.
  - Effect: resuming after a breakpoint executes the stopping instruction once instead of re-halting.
- **`retired`:** increments by 1 on every cycle with `core_en`=1 and wraps modulo 2^CNT_W. Only reset clears it.
- **`bp_hit`:** equals (`state`==BRK).

## Timing
- **Reset values** (asynchronous, immediate on `reset`=0):
  - `state`=IDLE, `core_en`=0, `retired`=0, `bp_hit`=0.
  - `div_cnt`=0, `skip_bp`=0, `step_q`=1.
  - `step_q`=1 means a button held through reset does not step.
- **Reset mid-pulse:** reset during a `core_en` pulse drops it immediately. The datapath sees no partial issue beyond its own reset.
- **Latencies:**
  - Step: edge detected in cycle t → `core_en` in cycle t+1, one cycle wide.
  - Run: entry to RUN in cycle r → first issue decision at r+eff−1, with `core_en` at r+eff. Subsequent pulses are exactly eff cycles apart.
- **Minimum issue spacing is 2 cycles.** `rate_div` of 0, 1 or 2 all yield one pulse per 2 cycles. This guarantees `pc` has updated before the next decision samples it.
- **`rate_div` changes** take effect at the next `div_cnt` comparison. If `div_cnt` already exceeds the new eff−1, the decision fires and `div_cnt` reloads to 0.
- **In-flight pulse:** a `halt_req` or `run_sw` drop in the same cycle as a registered `core_en` does not cancel that pulse. It only prevents further decisions.
- **Simultaneous events:**
  - A step edge in IDLE together with `run_sw` rising: step wins. State stays IDLE this cycle and RUN is entered on the next cycle if `run_sw` is still 1.
  - Breakpoint match together with halt opcode: a single BRK entry.

## Test plan
- **Reset and step:** release reset with `step_pb`=1 held → no `core_en`. Toggle `step_pb` 0→1 → exactly one `core_en` one cycle after the edge, `retired`=1, `state`=00.
- **Run rate:** `rate_div`=5, `run_sw`=1 → `core_en` every 5 cycles, first pulse 5 cycles after entering RUN. With `rate_div`=0 → every 2 cycles.
- **Breakpoint and resume:**
  - `bp_en`=1, `bp_addr`=8'h06, PC increments by 1 per issue from 0 → 6 pulses, `state`=10, `bp_hit`=1, `retired`=6.
  - `run_sw` 1→0→1 → `state`=01 and execution resumes with pc=06 issued once.
  - With `bp_addr` held at 8'h06, a revisit of PC 06 halts again.
- **Halt opcode:** `opcode`=4'hF presented in RUN → BRK with no pulse. A step edge in BRK → one pulse, `state`=00.
- **Halt priority:** `halt_req`=1 in RUN at a decision point → no pulse, `state`=00. With `rate_div`=2, a pulse already registered when `halt_req` rises still completes.
- **Wrap and async reset:** with CNT_W=4, 17 steps → `retired`=1. Assert `reset`=0 mid-RUN, asynchronously between clock edges → `core_en`=0, `state`=00, `retired`=0 before the next edge.
